ram_port_arbiter: RTL and testbench

//  Shares the single-port main RAM (512 x 32-bit words) between the pipeline's instruction-fetch (IF)
//  and memory-stage (MEM) requesters. Issues one RAM access per cycle and returns read data tagged to
//  the owner after a fixed latency. Gives stall signals to the hazard logic and drains on stop for dump.

---
 rtl/ram_port_arbiter.sv | 158 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch (IF) and memory stage (MEM).
// One access per cycle, tagged read returns after a fixed latency, and a stop/drain/halt
// sequence that frees the RAM for an external dump.
module ram_port_arbiter #(
    parameter int unsigned AW         = 9,
    parameter int unsigned DW         = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_if_req,
    input  logic [AW-1:0] i_if_addr,
    output logic          o_if_gnt,
    output logic          o_if_rvalid,
    output logic [DW-1:0] o_if_rdata,
    input  logic          i_mem_req,
    input  logic          i_mem_we,
    input  logic [AW-1:0] i_mem_addr,
    input  logic [DW-1:0] i_mem_wdata,
    output logic          o_mem_gnt,
    output logic          o_mem_rvalid,
    output logic [DW-1:0] o_mem_rdata,
    output logic          o_if_stall,
    output logic          o_mem_stall,
    input  logic          i_stop,
    output logic          o_halted,
    output logic          o_ram_en,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_addr,
    output logic [DW-1:0] o_ram_wdata,
    input  logic [DW-1:0] i_ram_rdata
);

    typedef enum logic [1:0] {StRun, StDrain, StHalt} state_e;

    localparam logic [3:0]        StarveMax = 4'(STARVE_MAX);
    // Head of the tag pipe is the top bit; everything below it is still in flight.
    localparam logic [RD_LAT-1:0] HeadMask  = RD_LAT'(1) << (RD_LAT - 1);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [3:0]        r_starve;
    logic [RD_LAT-1:0] r_tag_vld;
    logic [RD_LAT-1:0] r_tag_mem;
    logic [DW-1:0]     r_if_rdata;
    logic [DW-1:0]     r_mem_rdata;

    logic w_run;
    logic w_if_gnt;
    logic w_mem_gnt;
    logic w_rd_push;
    logic w_busy;
    logic w_head_if;
    logic w_head_mem;

    // Grant selection: MEM first unless IF has been starved long enough.
    always_comb begin
        w_run     = i_rst_n && (r_state == StRun);
        w_if_gnt  = 1'b0;
        w_mem_gnt = 1'b0;
        if (w_run) begin
            if (i_if_req && (r_starve == StarveMax)) begin
                w_if_gnt = 1'b1;
            end else if (i_mem_req) begin
                w_mem_gnt = 1'b1;
            end else if (i_if_req) begin
                w_if_gnt = 1'b1;
            end
        end
    end

    // Tag pipe decode: reads push a tag, the head routes RAM data to its owner.
    always_comb begin
        w_rd_push  = w_if_gnt || (w_mem_gnt && !i_mem_we);
        w_busy     = |(r_tag_vld & ~HeadMask);
        w_head_if  = r_tag_vld[RD_LAT-1] && !r_tag_mem[RD_LAT-1];
        w_head_mem = r_tag_vld[RD_LAT-1] && r_tag_mem[RD_LAT-1];
    end

    // Stop handling: stop drains in-flight reads, then parks in HALT until stop drops.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StRun: begin
                if (i_stop) w_state_nxt = StDrain;
            end
            StDrain: begin
                if (!i_stop) begin
                    w_state_nxt = StRun;
                end else if (!w_busy) begin
                    w_state_nxt = StHalt;
                end
            end
            StHalt: begin
                if (!i_stop) w_state_nxt = StRun;
            end
            default: w_state_nxt = StRun;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StRun;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Starvation counter: counts consecutive IF denials, saturating.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve <= 4'd0;
        end else if (!i_if_req || w_if_gnt) begin
            r_starve <= 4'd0;
        end else if (r_starve != StarveMax) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    // Tag shift pipe, one stage per cycle of RAM read latency; reset drops all tags.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tag_vld <= '0;
            r_tag_mem <= '0;
        end else begin
            r_tag_vld <= (r_tag_vld << 1) | RD_LAT'(w_rd_push);
            r_tag_mem <= (r_tag_mem << 1) | RD_LAT'(w_mem_gnt);
        end
    end

    // Read-data hold registers keep the last returned word per owner.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
        end else begin
            if (w_head_if)  r_if_rdata  <= i_ram_rdata;
            if (w_head_mem) r_mem_rdata <= i_ram_rdata;
        end
    end

    assign o_if_gnt     = w_if_gnt;
    assign o_mem_gnt    = w_mem_gnt;
    assign o_if_rvalid  = w_head_if;
    assign o_mem_rvalid = w_head_mem;
    assign o_if_rdata   = w_head_if  ? i_ram_rdata : r_if_rdata;
    assign o_mem_rdata  = w_head_mem ? i_ram_rdata : r_mem_rdata;
    assign o_if_stall   = i_rst_n && i_if_req && !w_if_gnt;
    assign o_mem_stall  = i_rst_n && i_mem_req && !w_mem_gnt;
    assign o_halted     = (r_state == StHalt);
    assign o_ram_en     = w_if_gnt || w_mem_gnt;
    assign o_ram_we     = w_mem_gnt && i_mem_we;
    assign o_ram_addr   = w_if_gnt ? i_if_addr : (w_mem_gnt ? i_mem_addr : '0);
    assign o_ram_wdata  = w_mem_gnt ? i_mem_wdata : '0;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: RAM model, transaction-level reference model,
// table-driven vectors, directed corner sequences and a randomized run.
module tb_ram_port_arbiter;

    localparam int unsigned AW         = 9;
    localparam int unsigned DW         = 32;
    localparam int unsigned RD_LAT     = 1;
    localparam int unsigned STARVE_MAX = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req, mem_req, mem_we, stop;
    logic [AW-1:0] if_addr, mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          if_gnt, if_rvalid, mem_gnt, mem_rvalid, if_stall, mem_stall, halted;
    logic [DW-1:0] if_rdata, mem_rdata;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(
        .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr),
        .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_mem_req(mem_req), .i_mem_we(mem_we), .i_mem_addr(mem_addr),
        .i_mem_wdata(mem_wdata),
        .o_mem_gnt(mem_gnt), .o_mem_rvalid(mem_rvalid), .o_mem_rdata(mem_rdata),
        .o_if_stall(if_stall), .o_mem_stall(mem_stall),
        .i_stop(stop), .o_halted(halted),
        .o_ram_en(ram_en), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
        .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'hC0DE0000 ^ (32'(i) * 32'h00010003);
    endfunction

    // Synchronous write-first RAM, latency 1, preloaded on the first edge.
    logic [DW-1:0] ram [512];
    bit            ram_loaded = 1'b0;
    always @(posedge clk) begin
        if (!ram_loaded) begin
            for (int i = 0; i < 512; i++) ram[i] <= init_word(i);
            ram_loaded <= 1'b1;
        end else if (ram_en) begin
            if (ram_we) begin
                ram[ram_addr] <= ram_wdata;
                ram_rdata     <= ram_wdata;
            end else begin
                ram_rdata <= ram[ram_addr];
            end
        end
    end

    // Reference model: shadow memory, queue of expected returns, starve count, mode.
    typedef struct {
        int          due;
        bit          own_mem;
        logic [31:0] data;
    } ret_t;

    logic [31:0] shadow [512];
    ret_t        rq[$];
    int          cyc;
    int          m_mode;    // 0 running, 1 draining, 2 halted
    int          m_starve;
    logic [31:0] m_if_last, m_mem_last;
    bit          g_if, g_mem;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        m_mode     = 0;
        m_starve   = 0;
        m_if_last  = '0;
        m_mem_last = '0;
        g_if       = 1'b0;
        g_mem      = 1'b0;
    endtask

    // Sample at the falling edge, compare against the model, then advance the model.
    task automatic sample();
        bit          e_if, e_mem, e_ifv, e_memv;
        logic [31:0] e_ifd, e_memd;
        logic [8:0]  e_addr;
        ret_t        r;
        @(negedge clk);
        e_if  = 1'b0;
        e_mem = 1'b0;
        if (m_mode == 0) begin
            if (if_req && m_starve == int'(STARVE_MAX)) e_if = 1'b1;
            else if (mem_req)                           e_mem = 1'b1;
            else if (if_req)                            e_if = 1'b1;
        end
        e_ifv  = 1'b0;
        e_memv = 1'b0;
        e_ifd  = m_if_last;
        e_memd = m_mem_last;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            if (rq[0].own_mem) begin
                e_memv = 1'b1;
                e_memd = rq[0].data;
            end else begin
                e_ifv = 1'b1;
                e_ifd = rq[0].data;
            end
        end
        e_addr = e_if ? if_addr : (e_mem ? mem_addr : 9'd0);
        chk("if_gnt", if_gnt, e_if);
        chk("mem_gnt", mem_gnt, e_mem);
        chk("if_stall", if_stall, if_req & ~e_if);
        chk("mem_stall", mem_stall, mem_req & ~e_mem);
        chk("if_rvalid", if_rvalid, e_ifv);
        chk("mem_rvalid", mem_rvalid, e_memv);
        chk("if_rdata", if_rdata, e_ifd);
        chk("mem_rdata", mem_rdata, e_memd);
        chk("halted", halted, m_mode == 2);
        chk("ram_en", ram_en, e_if | e_mem);
        chk("ram_we", ram_we, e_mem & mem_we);
        chk("ram_addr", ram_addr, e_addr);
        if (e_ifv || e_memv) begin
            void'(rq.pop_front());
            m_if_last  = e_ifd;
            m_mem_last = e_memd;
        end
        if (e_mem && mem_we) begin
            shadow[mem_addr] = mem_wdata;
        end else if (e_mem || e_if) begin
            r.due     = cyc + int'(RD_LAT);
            r.own_mem = e_mem;
            r.data    = shadow[e_addr];
            rq.push_back(r);
        end
        if (!if_req || e_if)                     m_starve = 0;
        else if (m_starve < int'(STARVE_MAX))    m_starve++;
        case (m_mode)
            0:       if (stop) m_mode = 1;
            1:       if (!stop) m_mode = 0; else if (rq.size() == 0) m_mode = 2;
            default: if (!stop) m_mode = 0;
        endcase
        g_if  = e_if;
        g_mem = e_mem;
        cyc++;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        sample();
        adv();
    endtask

    task automatic idle(input int n);
        if_req  = 1'b0;
        mem_req = 1'b0;
        mem_we  = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct {
        bit          if_req;
        bit          mem_req;
        bit          mem_we;
        logic [8:0]  if_addr;
        logic [8:0]  mem_addr;
        logic [31:0] wdata;
        bit          e_if_gnt;
        bit          e_mem_gnt;
        bit          e_if_stall;
        bit          e_mem_stall;
    } vec_t;

    vec_t tbl[11];

    initial begin
        for (int i = 0; i < 512; i++) shadow[i] = init_word(i);
        tbl[0]  = '{0, 0, 0, 9'h000, 9'h000, 32'h0,        0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 9'h003, 9'h000, 32'h0,        1, 0, 0, 0};
        tbl[2]  = '{0, 1, 0, 9'h000, 9'h004, 32'h0,        0, 1, 0, 0};
        tbl[3]  = '{1, 1, 0, 9'h005, 9'h006, 32'h0,        0, 1, 1, 0};
        tbl[4]  = '{1, 1, 0, 9'h005, 9'h007, 32'h0,        0, 1, 1, 0};
        tbl[5]  = '{1, 1, 0, 9'h005, 9'h008, 32'h0,        0, 1, 1, 0};
        tbl[6]  = '{1, 1, 0, 9'h005, 9'h009, 32'h0,        1, 0, 0, 1};
        tbl[7]  = '{1, 1, 0, 9'h00A, 9'h009, 32'h0,        0, 1, 1, 0};
        tbl[8]  = '{0, 1, 1, 9'h000, 9'h040, 32'h12345678, 0, 1, 0, 0};
        tbl[9]  = '{1, 1, 0, 9'h040, 9'h040, 32'h0,        0, 1, 1, 0};
        tbl[10] = '{1, 0, 0, 9'h040, 9'h000, 32'h0,        1, 0, 0, 0};

        rst_n = 1'b0; stop = 1'b0;
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0;
        if_addr = '0; mem_addr = '0; mem_wdata = '0;
        cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        // Outputs stay quiet in reset even with requests pending.
        if_req = 1'b1; mem_req = 1'b1;
        #1;
        chk("rst_if_gnt", if_gnt, 1'b0);
        chk("rst_mem_gnt", mem_gnt, 1'b0);
        chk("rst_if_stall", if_stall, 1'b0);
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_if_rdata", if_rdata, 32'h0);
        if_req = 1'b0; mem_req = 1'b0;
        rst_n = 1'b1;
        idle(2);

        // Table-driven arbitration vectors, applied back to back.
        for (int v = 0; v < 11; v++) begin
            if_req = tbl[v].if_req; mem_req = tbl[v].mem_req; mem_we = tbl[v].mem_we;
            if_addr = tbl[v].if_addr; mem_addr = tbl[v].mem_addr; mem_wdata = tbl[v].wdata;
            sample();
            chk("tbl_if_gnt", if_gnt, tbl[v].e_if_gnt);
            chk("tbl_mem_gnt", mem_gnt, tbl[v].e_mem_gnt);
            chk("tbl_if_stall", if_stall, tbl[v].e_if_stall);
            chk("tbl_mem_stall", mem_stall, tbl[v].e_mem_stall);
            adv();
        end
        idle(3);

        // IF-only stream over addresses 0..2.
        for (int k = 0; k < 4; k++) begin
            if_req  = (k < 3);
            if_addr = 9'(k);
            sample();
            chk("s1_if_gnt", if_gnt, k < 3);
            if (k > 0) begin
                chk("s1_if_rvalid", if_rvalid, 1'b1);
                chk("s1_if_rdata", if_rdata, init_word(k - 1));
            end
            adv();
        end
        idle(2);

        // Simultaneous requests: MEM first, IF the cycle after.
        if_req = 1'b1; if_addr = 9'h020;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 9'h010;
        sample();
        chk("s2_mem_gnt", mem_gnt, 1'b1);
        chk("s2_if_gnt", if_gnt, 1'b0);
        chk("s2_if_stall", if_stall, 1'b1);
        adv();
        mem_req = 1'b0;
        sample();
        chk("s2_if_gnt_next", if_gnt, 1'b1);
        chk("s2_mem_rdata", mem_rdata, init_word(16));
        adv();
        idle(3);

        // Starvation: IF loses three times, then wins over a still-pending MEM.
        if_req = 1'b1; if_addr = 9'h050;
        for (int k = 0; k < 5; k++) begin
            mem_req = 1'b1; mem_we = 1'b0; mem_addr = 9'(9'h060 + k);
            sample();
            chk("s3_if_gnt", if_gnt, k == 3);
            chk("s3_mem_gnt", mem_gnt, k != 3);
            adv();
            if (k == 3) if_req = 1'b0;
        end
        idle(3);

        // Write then immediate read-back at the top address.
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 9'h1FF; mem_wdata = 32'hDEADBEEF;
        sample();
        chk("s4_wr_gnt", mem_gnt, 1'b1);
        chk("s4_ram_we", ram_we, 1'b1);
        adv();
        mem_we = 1'b0;
        sample();
        chk("s4_rd_gnt", mem_gnt, 1'b1);
        adv();
        mem_req = 1'b0;
        sample();
        chk("s4_rvalid", mem_rvalid, 1'b1);
        chk("s4_rdata", mem_rdata, 32'hDEADBEEF);
        adv();
        idle(2);

        // Stop rises with a read grant: the read returns, then the block halts.
        if_req = 1'b1; if_addr = 9'h007; stop = 1'b1;
        sample();
        chk("s5_if_gnt", if_gnt, 1'b1);
        adv();
        if_req = 1'b0;
        sample();
        chk("s5_if_rvalid", if_rvalid, 1'b1);
        chk("s5_if_rdata", if_rdata, init_word(7));
        chk("s5_not_halted", halted, 1'b0);
        adv();
        sample();
        chk("s5_halted", halted, 1'b1);
        adv();
        if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0; mem_addr = 9'h011;
        sample();
        chk("s5_halt_if_gnt", if_gnt, 1'b0);
        chk("s5_halt_mem_gnt", mem_gnt, 1'b0);
        chk("s5_halt_stall", if_stall & mem_stall, 1'b1);
        chk("s5_halt_ram_en", ram_en, 1'b0);
        adv();
        stop = 1'b0;
        step();
        sample();
        chk("s5_resumed", halted, 1'b0);
        adv();
        idle(4);

        // Asynchronous reset between a read grant and its return.
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 9'h033;
        sample();
        chk("s6_mem_gnt", mem_gnt, 1'b1);
        adv();
        rst_n = 1'b0;
        #1;
        chk("s6_rst_rvalid", mem_rvalid, 1'b0);
        chk("s6_rst_mem_gnt", mem_gnt, 1'b0);
        chk("s6_rst_stall", mem_stall, 1'b0);
        chk("s6_rst_ram_en", ram_en, 1'b0);
        chk("s6_rst_rdata", mem_rdata, 32'h0);
        mem_req = 1'b0;
        adv();
        rst_n = 1'b1;
        model_reset();
        sample();
        chk("s6_no_rvalid", mem_rvalid | if_rvalid, 1'b0);
        adv();
        idle(2);

        // Randomized traffic; requests are held until the model says they were granted.
        for (int n = 0; n < 500; n++) begin
            if (!if_req || g_if) begin
                if_req  = ($urandom_range(0, 9) < 6);
                if_addr = 9'($urandom_range(0, 511));
            end
            if (!mem_req || g_mem) begin
                mem_req   = ($urandom_range(0, 9) < 6);
                mem_we    = ($urandom_range(0, 2) == 0);
                mem_addr  = 9'($urandom_range(0, 31));
                mem_wdata = $urandom;
            end
            if ($urandom_range(0, 24) == 0) stop = ~stop;
            step();
        end
        stop = 1'b0;
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
